// File: rtl/wb_pkg.sv
// Shared types and constants for the write-buffer drain arbiter.
// Optional parity checking is enabled with `WB_PARITY_CHECK_EN.
package wb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  localparam int NUM_CH      = 2;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_DEF = 256;
endpackage

// File: rtl/wb_drain_arbiter_if.sv
// Downstream Y-port: 4-phase YREQ/YACK with data and parity flag.
// The arbiter uses the master modport; the output device uses slave.
interface wb_drain_arbiter_if;
  import wb_pkg::*;
  logic              YREQ;
  logic              YACK;
  logic [DATA_W-1:0] YDATA;
  logic              YPARITY;

  modport master (
    output YREQ,
    output YDATA,
    output YPARITY,
    input  YACK
  );

  modport slave (
    input  YREQ,
    input  YDATA,
    input  YPARITY,
    output YACK
  );
endinterface

// File: rtl/wb_parity_chk.sv
// Compares recomputed even parity of a head word with its stored bit.
// Instantiated only when `WB_PARITY_CHECK_EN is defined.
module wb_parity_chk
  import wb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  output logic              mismatch
);
  assign mismatch = (^data) ^ par;
endmodule

// File: rtl/wb_drain_arbiter.sv
// Round-robin drain of two write-buffer FIFOs onto one YREQ/YACK port.
// `WB_PARITY_CHECK_EN adds the head-word parity check and error counter.
module wb_drain_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                HRESETn,
  input  logic                ch0_req,
  input  logic [DATA_W-1:0]   ch0_data,
  input  logic                ch0_par,
  output logic                ch0_pop,
  input  logic                ch1_req,
  input  logic [DATA_W-1:0]   ch1_data,
  input  logic                ch1_par,
  output logic                ch1_pop,
  wb_drain_arbiter_if.master  y,
  output logic                grant,
  output logic                busy,
  output logic                timeout_err,
  input  logic                clr_err,
  output logic [CNT_W-1:0]    par_err_cnt,
  output logic [CNT_W-1:0]    xfer_cnt
);
  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              yreq_q, yreq_d;
  logic [DATA_W-1:0] ydata_q, ydata_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              pop0_q, pop0_d;
  logic              pop1_q, pop1_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              terr_q, terr_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic              ypar_q, ypar_d;
  logic [CNT_W-1:0]  perr_q, perr_d;

  logic              sel;
  logic [DATA_W-1:0] sel_data;
  logic              sel_par;
  logic              mism;

  // Contention goes to the channel that did not finish last.
  assign sel      = (ch0_req & ch1_req) ? ~last_q : ch1_req;
  assign sel_data = sel ? ch1_data : ch0_data;
  assign sel_par  = sel ? ch1_par : ch0_par;

`ifdef WB_PARITY_CHECK_EN
  wb_parity_chk u_chk (
    .data     (sel_data),
    .par      (sel_par),
    .mismatch (mism)
  );
`else
  logic unused_par;
  assign unused_par = sel_par;
  assign mism       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    yreq_d   = yreq_q;
    ydata_d  = ydata_q;
    grant_d  = grant_q;
    last_d   = last_q;
    pop0_d   = 1'b0;
    pop1_d   = 1'b0;
    to_cnt_d = to_cnt_q;
    terr_d   = terr_q;
    xfer_d   = xfer_q;
    ypar_d   = ypar_q;
    perr_d   = perr_q;
    unique case (state_q)
      IDLE: begin
        // A stale YACK blocks the next request until it falls.
        if ((ch0_req | ch1_req) && !y.YACK) begin
          ydata_d  = sel_data;
          ypar_d   = mism;
          grant_d  = sel;
          yreq_d   = 1'b1;
          to_cnt_d = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (y.YACK) begin
          yreq_d  = 1'b0;
          pop0_d  = ~grant_q;
          pop1_d  = grant_q;
          last_d  = grant_q;
          xfer_d  = xfer_q + 1'b1;
          perr_d  = perr_q + CNT_W'(ypar_q);
          state_d = RELEASE;
        end else if (to_cnt_q == TO_MAX) begin
          yreq_d  = 1'b0;
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!y.YACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_err) begin
      terr_d = 1'b0;
      perr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      yreq_q   <= 1'b0;
      ydata_q  <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      pop0_q   <= 1'b0;
      pop1_q   <= 1'b0;
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
      xfer_q   <= '0;
      ypar_q   <= 1'b0;
      perr_q   <= '0;
    end else begin
      state_q  <= state_d;
      yreq_q   <= yreq_d;
      ydata_q  <= ydata_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      pop0_q   <= pop0_d;
      pop1_q   <= pop1_d;
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
      xfer_q   <= xfer_d;
      ypar_q   <= ypar_d;
      perr_q   <= perr_d;
    end
  end

  assign y.YREQ      = yreq_q;
  assign y.YDATA     = ydata_q;
  assign y.YPARITY   = ypar_q;
  assign ch0_pop     = pop0_q;
  assign ch1_pop     = pop1_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;
  assign xfer_cnt    = xfer_q;
  assign par_err_cnt = perr_q;
endmodule

// File: tb/tb_wb_drain_arbiter.sv
// Scoreboard bench for wb_drain_arbiter with TIMEOUT=8.
// Honours `WB_PARITY_CHECK_EN when computing expected parity results.
module tb_wb_drain_arbiter;
  import wb_pkg::*;

  localparam int TO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          HRESETn = 1'b0;
  logic          ch0_req, ch1_req, ch0_par, ch1_par;
  logic [31:0]   ch0_data, ch1_data;
  logic          ch0_pop, ch1_pop;
  logic          grant, busy, timeout_err;
  logic          clr_err = 1'b0;
  logic [CW-1:0] par_err_cnt, xfer_cnt;

  wb_drain_arbiter_if y ();

  always #5 clk = ~clk;

  wb_drain_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .HRESETn     (HRESETn),
    .ch0_req     (ch0_req),
    .ch0_data    (ch0_data),
    .ch0_par     (ch0_par),
    .ch0_pop     (ch0_pop),
    .ch1_req     (ch1_req),
    .ch1_data    (ch1_data),
    .ch1_par     (ch1_par),
    .ch1_pop     (ch1_pop),
    .y           (y),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err),
    .par_err_cnt (par_err_cnt),
    .xfer_cnt    (xfer_cnt)
  );

  // Source FIFO models: tasks write, the pop monitor reads.
  logic [32:0] m0 [16];
  logic [32:0] m1 [16];
  logic [3:0]  wr0 = '0, wr1 = '0, rd0 = '0, rd1 = '0;
  int          bad_pop = 0;

  assign ch0_req  = (wr0 != rd0);
  assign ch1_req  = (wr1 != rd1);
  assign ch0_data = m0[rd0][31:0];
  assign ch0_par  = m0[rd0][32];
  assign ch1_data = m1[rd1][31:0];
  assign ch1_par  = m1[rd1][32];

  always @(negedge clk) begin
    if (ch0_pop) begin
      if (wr0 == rd0) bad_pop++;
      rd0 = rd0 + 1'b1;
    end
    if (ch1_pop) begin
      if (wr1 == rd1) bad_pop++;
      rd1 = rd1 + 1'b1;
    end
  end

  typedef struct packed {
    logic        ch;
    logic [31:0] d;
    logic        p;
  } exp_t;

  exp_t sb [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_xfer = 0;
  int   exp_perr = 0;

  function automatic logic exp_par(input logic [31:0] d, input logic p);
`ifdef WB_PARITY_CHECK_EN
    return (^d) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load(input logic ch, input logic [31:0] d, input logic p);
    if (ch) begin
      m1[wr1] = {p, d};
      wr1 = wr1 + 1'b1;
    end else begin
      m0[wr0] = {p, d};
      wr0 = wr0 + 1'b1;
    end
    sb.push_back('{ch: ch, d: d, p: p});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    y.YACK  = 1'b0;
    HRESETn = 1'b0;
    repeat (2) @(negedge clk);
    HRESETn  = 1'b1;
    exp_xfer = 0;
    exp_perr = 0;
  endtask

  task automatic wait_yreq(input string nm);
    int n;
    n = 0;
    while (y.YREQ !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (y.YREQ !== 1'b1) begin
      $display("FAIL %s_wait: YREQ=%b after %0d cycles, want 1", nm, y.YREQ, n);
      miscompares++;
    end
  endtask

  // Acts as the output device for the word at the head of the scoreboard.
  task automatic serve(input int dly, input int hold);
    exp_t        e;
    logic [1:0]  wp;
    wait_yreq("serve");
    if (y.YREQ !== 1'b1 || sb.size() == 0) return;
    e = sb.pop_front();
    vectors += 3;
    if (y.YDATA !== e.d) begin
      $display("FAIL ydata: got %h want %h", y.YDATA, e.d);
      miscompares++;
    end
    if (grant !== e.ch) begin
      $display("FAIL grant: got %b want %b", grant, e.ch);
      miscompares++;
    end
    if (y.YPARITY !== exp_par(e.d, e.p)) begin
      $display("FAIL yparity: got %b want %b", y.YPARITY, exp_par(e.d, e.p));
      miscompares++;
    end
    repeat (dly) @(negedge clk);
    y.YACK = 1'b1;
    @(negedge clk);
    wp = e.ch ? 2'b10 : 2'b01;
    vectors += 2;
    if ({ch1_pop, ch0_pop} !== wp) begin
      $display("FAIL pop: got %b want %b", {ch1_pop, ch0_pop}, wp);
      miscompares++;
    end
    if (y.YREQ !== 1'b0) begin
      $display("FAIL yreq_drop: got %b want 0", y.YREQ);
      miscompares++;
    end
    exp_xfer++;
    if (exp_par(e.d, e.p)) exp_perr++;
    repeat (hold) begin
      @(negedge clk);
      vectors++;
      if (y.YREQ !== 1'b0 || busy !== 1'b1 || (ch0_pop | ch1_pop) !== 1'b0) begin
        $display("FAIL release_hold: yreq=%b busy=%b pops=%b want 0 1 00",
                 y.YREQ, busy, {ch1_pop, ch0_pop});
        miscompares++;
      end
    end
    y.YACK = 1'b0;
    @(negedge clk);
    vectors += 3;
    if ({ch1_pop, ch0_pop} !== 2'b00) begin
      $display("FAIL pop_len: got %b want 00", {ch1_pop, ch0_pop});
      miscompares++;
    end
    if (xfer_cnt !== CW'(exp_xfer)) begin
      $display("FAIL xfer_cnt: got %0d want %0d", xfer_cnt, exp_xfer);
      miscompares++;
    end
    if (par_err_cnt !== CW'(exp_perr)) begin
      $display("FAIL par_err_cnt: got %0d want %0d", par_err_cnt, exp_perr);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({y.YREQ, y.YDATA, y.YPARITY, ch0_pop, ch1_pop, grant, busy,
         timeout_err, par_err_cnt, xfer_cnt} !== '0) begin
      $display("FAIL reset: yreq=%b ydata=%h ypar=%b pops=%b grant=%b busy=%b terr=%b perr=%0d xfer=%0d want all 0",
               y.YREQ, y.YDATA, y.YPARITY, {ch1_pop, ch0_pop}, grant, busy,
               timeout_err, par_err_cnt, xfer_cnt);
      miscompares++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    load(1'b0, 32'hDEADBEEF, 1'b0);
    serve(2, 0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    load(1'b0, 32'h1111_0000, 1'b0);
    load(1'b1, 32'h2222_0001, 1'b1);
    load(1'b0, 32'h3333_0003, 1'b0);
    load(1'b1, 32'h4444_0007, 1'b1);
    repeat (4) serve(0, 0);
  endtask

  task automatic test_timeout();
    int   n;
    logic [3:0] rd_save;
    apply_reset();
    load(1'b0, 32'hCAFE_F00D, 1'b0);
    rd_save = rd0;
    wait_yreq("timeout");
    n = 0;
    while (y.YREQ === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors += 4;
    if (n != TO) begin
      $display("FAIL timeout_len: YREQ high %0d cycles, want %0d", n, TO);
      miscompares++;
    end
    if (timeout_err !== 1'b1) begin
      $display("FAIL timeout_err: got %b want 1", timeout_err);
      miscompares++;
    end
    if (rd0 !== rd_save) begin
      $display("FAIL timeout_pop: rd=%0d want %0d", rd0, rd_save);
      miscompares++;
    end
    if (xfer_cnt !== '0) begin
      $display("FAIL timeout_xfer: got %0d want 0", xfer_cnt);
      miscompares++;
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL clr_err: timeout_err=%b want 0", timeout_err);
      miscompares++;
    end
    serve(1, 0);
  endtask

  task automatic test_parity();
    apply_reset();
    load(1'b1, 32'h0000_0001, 1'b0);
    serve(0, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err  = 1'b0;
    exp_perr = 0;
    vectors++;
    if (par_err_cnt !== '0) begin
      $display("FAIL par_clr: got %0d want 0", par_err_cnt);
      miscompares++;
    end
    load(1'b0, 32'h0000_0003, 1'b0);
    load(1'b1, 32'h8000_0000, 1'b1);
    serve(0, 0);
    serve(0, 0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    load(1'b0, 32'h0A0A_0A0A, 1'b0);
    serve(0, 0);
    load(1'b0, 32'h0C0C_0C0C, 1'b0);
    load(1'b1, 32'h0B0B_0B0B, 1'b1);
    wait_yreq("async");
    vectors++;
    if (grant !== 1'b1) begin
      $display("FAIL async_pre_grant: got %b want 1", grant);
      miscompares++;
    end
    #2 HRESETn = 1'b0;
    #1;
    vectors++;
    if ({y.YREQ, busy, grant, ch0_pop, ch1_pop} !== 5'b0) begin
      $display("FAIL async_reset: yreq=%b busy=%b grant=%b pops=%b want 0",
               y.YREQ, busy, grant, {ch1_pop, ch0_pop});
      miscompares++;
    end
    @(negedge clk);
    HRESETn  = 1'b1;
    exp_xfer = 0;
    exp_perr = 0;
    serve(1, 0);
    serve(0, 0);
  endtask

  task automatic test_yack_hold();
    apply_reset();
    y.YACK = 1'b1;
    load(1'b0, 32'h5555_AAAA, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (y.YREQ !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL stale_yack: yreq=%b busy=%b want 0 0", y.YREQ, busy);
      miscompares++;
    end
    y.YACK = 1'b0;
    load(1'b1, 32'h6666_0000, 1'b0);
    serve(0, 4);
    serve(0, 0);
  endtask

  initial begin
    y.YACK = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_parity();
    test_async_reset();
    test_yack_hold();
    repeat (2) @(negedge clk);
    vectors += 2;
    if (bad_pop != 0) begin
      $display("FAIL pop_empty: %0d pops on empty FIFO, want 0", bad_pop);
      miscompares++;
    end
    if (sb.size() != 0 || ch0_req || ch1_req) begin
      $display("FAIL drain: %0d expected words left, req=%b%b want none",
               sb.size(), ch1_req, ch0_req);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
